// File: rtl/controller_pkg.sv
// controller_pkg: opcodes, FSM states and datapath select encodings shared by the RISC-V control units
package controller_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_HALT   = 7'b1110101;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT, S_FAULT
  } state_t;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_PASS   = 2'b11;

  localparam logic [1:0] RW_ALU   = 2'b00;
  localparam logic [1:0] RW_PC4   = 2'b01;
  localparam logic [1:0] RW_IMM   = 2'b10;
  localparam logic [1:0] RW_PCIMM = 2'b11;

  function automatic logic is_legal(input logic [6:0] op);
    return op inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_LUI, OP_AUIPC,
                      OP_BRANCH, OP_JAL, OP_JALR, OP_HALT};
  endfunction

  function automatic logic [1:0] alu_op(input logic [6:0] op);
    return (op == OP_BRANCH) ? ALU_BRANCH :
           (op inside {OP_R, OP_I}) ? ALU_FUNCT :
           (op inside {OP_LUI, OP_JAL, OP_JALR}) ? ALU_PASS : ALU_ADD;
  endfunction

  function automatic logic alu_src(input logic [6:0] op);
    return op inside {OP_LOAD, OP_STORE, OP_I, OP_LUI};
  endfunction
endpackage

// File: rtl/multicycle_controller_wait_timer.sv
// wait_timer: counts stalled handshake cycles and flags the last allowed one
module wait_timer #(
  parameter int TIMEOUT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] r_cnt;

  // stalled-cycle count, restarted whenever the FSM changes state
  always_ff @(posedge clk) begin
    if (reset || clear) r_cnt <= '0;
    else if (enable) r_cnt <= r_cnt + W'(1);
  end

  // a ready in the limit cycle drops enable, so ready wins over expiry
  assign expired = (TIMEOUT != 0) && enable && (r_cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: fetch/decode/execute/mem/wb sequencer driving the RISC-V datapath controls
module multicycle_controller
  import controller_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Opcode,
  input  logic             IMemReady,
  input  logic             DMemReady,
  input  logic             Resume,
  output logic             IMemReq,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       ALUOp,
  output logic             ALUSrc,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             Branch,
  output logic             JALSel,
  output logic             JALRSel,
  output logic [1:0]       RWSel,
  output logic             Halted,
  output logic             Fault,
  output logic [CNT_W-1:0] RetireCount
);
  state_t           r_state, w_next;
  logic [6:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             w_load, w_store, w_branch, w_jal, w_jalr, w_auipc;
  logic             w_wait, w_expired, w_retire;

  assign w_load   = r_op == OP_LOAD;
  assign w_store  = r_op == OP_STORE;
  assign w_branch = r_op == OP_BRANCH;
  assign w_jal    = r_op == OP_JAL;
  assign w_jalr   = r_op == OP_JALR;
  assign w_auipc  = r_op == OP_AUIPC;

  assign w_wait = (r_state == S_FETCH && !IMemReady) || (r_state == S_MEM && !DMemReady);

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_next != r_state),
    .enable (w_wait),
    .expired(w_expired)
  );

  // state register; the opcode is captured only while decoding
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= Opcode;
    end
  end

  // next-state sequencing, stalls and fault entry
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:   w_next = IMemReady ? S_DECODE : w_expired ? S_FAULT : S_FETCH;
      S_DECODE:  w_next = (Opcode == OP_HALT) ? S_HALT : !is_legal(Opcode) ? S_FAULT : S_EXECUTE;
      S_EXECUTE: w_next = w_branch ? S_FETCH : (w_load || w_store) ? S_MEM : S_WB;
      S_MEM:     w_next = !DMemReady ? (w_expired ? S_FAULT : S_MEM) : w_store ? S_FETCH : S_WB;
      S_WB:      w_next = S_FETCH;
      S_HALT:    w_next = Resume ? S_FETCH : S_HALT;
      S_FAULT:   w_next = S_FAULT;
      default:   w_next = S_FAULT;
    endcase
  end

  // datapath controls per state, all forced low while reset is held
  always_comb begin
    IMemReq  = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    ALUOp    = ALU_ADD;
    ALUSrc   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    Branch   = 1'b0;
    JALSel   = 1'b0;
    JALRSel  = 1'b0;
    RWSel    = RW_ALU;
    Halted   = 1'b0;
    Fault    = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          IMemReq = 1'b1;
          IRWrite = IMemReady;
        end
        S_EXECUTE: begin
          ALUOp   = alu_op(r_op);
          ALUSrc  = alu_src(r_op);
          Branch  = w_branch;
          PCWrite = w_branch;
        end
        S_MEM: begin
          ALUOp    = alu_op(r_op);
          ALUSrc   = alu_src(r_op);
          MemRead  = w_load;
          MemWrite = w_store;
          PCWrite  = w_store && DMemReady;
        end
        S_WB: begin
          ALUOp    = alu_op(r_op);
          ALUSrc   = alu_src(r_op);
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          MemToReg = w_load;
          JALSel   = w_jal;
          JALRSel  = w_jalr;
          RWSel    = (w_jal || w_jalr) ? RW_PC4 : w_auipc ? RW_PCIMM : RW_ALU;
        end
        S_HALT: begin
          Halted  = 1'b1;
          PCWrite = Resume;
        end
        S_FAULT: Fault = 1'b1;
        default: Fault = 1'b0;
      endcase
    end
  end

  assign w_retire = (r_state == S_EXECUTE && w_branch) ||
                    (r_state == S_MEM && w_store && DMemReady) ||
                    (r_state == S_WB);

  // retired-instruction counter, wrapping at its width
  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign RetireCount = reset ? '0 : r_cnt;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle vectors checked by a scoreboard monitor
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] Opcode = '0;
  logic       IMemReady = 1'b0, DMemReady = 1'b0, Resume = 1'b0;
  logic       IMemReq, IRWrite, PCWrite, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite;
  logic       Branch, JALSel, JALRSel, Halted, Fault;
  logic [1:0] ALUOp, RWSel;
  logic [3:0] RetireCount;

  multicycle_controller #(.CNT_W(4), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .IMemReady(IMemReady),
    .DMemReady(DMemReady), .Resume(Resume), .IMemReq(IMemReq), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .RegWrite(RegWrite), .Branch(Branch),
    .JALSel(JALSel), .JALRSel(JALRSel), .RWSel(RWSel), .Halted(Halted),
    .Fault(Fault), .RetireCount(RetireCount)
  );

  always #5 clk = ~clk;

  localparam logic [20:0] IMQ = 21'h1 << 20, IRW = 21'h1 << 19, PCW = 21'h1 << 18;
  localparam logic [20:0] A01 = 21'h1 << 16, A10 = 21'h2 << 16, A11 = 21'h3 << 16;
  localparam logic [20:0] ASR = 21'h1 << 15, MRD = 21'h1 << 14, MWR = 21'h1 << 13;
  localparam logic [20:0] M2R = 21'h1 << 12, RGW = 21'h1 << 11, BRN = 21'h1 << 10;
  localparam logic [20:0] JLS = 21'h1 << 9, JRS = 21'h1 << 8, RW01 = 21'h1 << 6;
  localparam logic [20:0] RW11 = 21'h3 << 6, HLT = 21'h1 << 5, FLT = 21'h1 << 4;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, ADDI = 7'b0010011;
  localparam logic [6:0] AUIPC = 7'b0010111, BEQ = 7'b1100011, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, HALT = 7'b1110101, BAD = 7'b1111111;

  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          qc[$];
  logic [20:0] qe[$];
  string       qn[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [20:0] rc(input int n);
    return 21'(n & 15);
  endfunction

  task automatic st(input logic r, input logic [6:0] op, input logic im, input logic dm,
                    input logic rs, input logic [20:0] e, input string nm);
    reset = r; Opcode = op; IMemReady = im; DMemReady = dm; Resume = rs;
    qc.push_back(cyc); qe.push_back(e); qn.push_back(nm);
    @(posedge clk); #1;
  endtask

  logic [20:0] got;
  assign got = {IMemReq, IRWrite, PCWrite, ALUOp, ALUSrc, MemRead, MemWrite, MemToReg,
                RegWrite, Branch, JALSel, JALRSel, RWSel, Halted, Fault, RetireCount};

  always @(negedge clk) begin
    while (qc.size() != 0 && qc[0] < cyc) begin
      miscompares++;
      $display("FAIL %s: vector for cycle %0d never sampled", qn[0], qc[0]);
      void'(qc.pop_front()); void'(qe.pop_front()); void'(qn.pop_front());
    end
    if (qc.size() != 0 && qc[0] == cyc) begin
      vectors++;
      if (got !== qe[0]) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got %b required %b", qn[0], cyc, got, qe[0]);
      end
      void'(qc.pop_front()); void'(qe.pop_front()); void'(qn.pop_front());
    end
  end

  initial begin
    @(posedge clk); #1;
    st(1, ADDI, 1, 1, 1, 0, "reset_outputs_low");
    st(1, ADDI, 1, 1, 1, 0, "reset_outputs_low2");
    st(0, ADDI, 1, 1, 0, IMQ | IRW, "addi_fetch");
    st(0, ADDI, 1, 1, 0, 0, "addi_decode");
    st(0, ADDI, 1, 1, 0, A10 | ASR, "addi_exec");
    st(0, ADDI, 1, 1, 0, A10 | ASR | RGW | PCW, "addi_wb");
    st(0, LW, 1, 0, 0, IMQ | IRW | rc(1), "lw_fetch");
    st(0, LW, 1, 0, 0, rc(1), "lw_decode");
    st(0, LW, 1, 0, 0, ASR | rc(1), "lw_exec");
    for (int i = 0; i < 3; i++) st(0, LW, 1, 0, 0, ASR | MRD | rc(1), "lw_mem_wait");
    st(0, LW, 1, 1, 0, ASR | MRD | rc(1), "lw_mem_ready_at_limit");
    st(0, LW, 1, 1, 0, ASR | M2R | RGW | PCW | rc(1), "lw_wb");
    st(0, JAL, 1, 1, 0, IMQ | IRW | rc(2), "jal_fetch");
    st(0, JAL, 1, 1, 0, rc(2), "jal_decode");
    st(0, JAL, 1, 1, 0, A11 | rc(2), "jal_exec");
    st(0, JAL, 1, 1, 0, A11 | RGW | PCW | RW01 | JLS | rc(2), "jal_wb");
    st(0, BEQ, 1, 1, 0, IMQ | IRW | rc(3), "beq_fetch");
    st(0, BEQ, 1, 1, 0, rc(3), "beq_decode");
    st(0, BEQ, 1, 1, 0, A01 | BRN | PCW | rc(3), "beq_exec");
    st(0, JALR, 1, 1, 0, IMQ | IRW | rc(4), "jalr_fetch");
    st(0, JALR, 1, 1, 0, rc(4), "jalr_decode");
    st(0, JALR, 1, 1, 0, A11 | rc(4), "jalr_exec");
    st(0, JALR, 1, 1, 0, A11 | RGW | PCW | RW01 | JRS | rc(4), "jalr_wb");
    st(0, AUIPC, 1, 1, 0, IMQ | IRW | rc(5), "auipc_fetch");
    st(0, AUIPC, 1, 1, 0, rc(5), "auipc_decode");
    st(0, AUIPC, 1, 1, 0, rc(5), "auipc_exec");
    st(0, AUIPC, 1, 1, 0, RGW | PCW | RW11 | rc(5), "auipc_wb");
    st(0, SW, 1, 1, 0, IMQ | IRW | rc(6), "sw_fetch");
    st(0, SW, 1, 1, 0, rc(6), "sw_decode");
    st(0, SW, 1, 1, 0, ASR | rc(6), "sw_exec");
    st(0, SW, 1, 1, 0, ASR | MWR | PCW | rc(6), "sw_mem");
    st(0, HALT, 0, 1, 0, IMQ | rc(7), "fetch_wait");
    st(0, HALT, 0, 1, 0, IMQ | rc(7), "fetch_wait2");
    st(0, HALT, 1, 1, 0, IMQ | IRW | rc(7), "halt_fetch");
    st(0, HALT, 1, 1, 1, rc(7), "halt_decode_resume_ignored");
    st(0, HALT, 1, 1, 0, HLT | rc(7), "halted");
    st(0, ADDI, 1, 1, 0, HLT | rc(7), "halted_stays");
    st(0, ADDI, 1, 1, 1, HLT | PCW | rc(7), "resume_pcwrite");
    st(0, SW, 1, 1, 0, IMQ | IRW | rc(7), "after_resume_fetch");
    st(0, SW, 1, 1, 0, rc(7), "sw2_decode");
    st(0, SW, 1, 1, 0, ASR | rc(7), "sw2_exec");
    st(0, SW, 1, 0, 0, ASR | MWR | rc(7), "sw2_mem_wait");
    st(1, SW, 1, 1, 0, 0, "reset_in_mem");
    st(0, SW, 0, 1, 0, IMQ, "after_abort_fetch");
    for (int i = 0; i < 16; i++) begin
      st(0, ADDI, 1, 1, 0, IMQ | IRW | rc(i), "wrap_fetch");
      st(0, ADDI, 1, 1, 0, rc(i), "wrap_decode");
      st(0, ADDI, 1, 1, 0, A10 | ASR | rc(i), "wrap_exec");
      st(0, ADDI, 1, 1, 0, A10 | ASR | RGW | PCW | rc(i), "wrap_wb");
    end
    st(0, BAD, 1, 1, 0, IMQ | IRW, "bad_fetch_count_wrapped");
    st(0, BAD, 1, 1, 0, 0, "bad_decode");
    st(0, ADDI, 1, 1, 1, FLT, "illegal_fault");
    st(0, ADDI, 1, 1, 1, FLT, "illegal_fault_stays");
    st(1, ADDI, 0, 0, 0, 0, "fault_reset");
    for (int i = 0; i < 4; i++) st(0, ADDI, 0, 0, 0, IMQ, "timeout_wait");
    st(0, ADDI, 0, 0, 0, FLT, "timeout_fault");
    st(0, ADDI, 1, 1, 1, FLT, "timeout_fault_stays");
    st(1, ADDI, 1, 1, 0, 0, "timeout_reset");
    st(0, ADDI, 1, 1, 0, IMQ | IRW, "post_fault_fetch");
    @(negedge clk);
    if (qc.size() != 0) begin
      miscompares += qc.size();
      $display("FAIL scoreboard_drain: %0d vectors left unchecked, required 0", qc.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
